dmem_lsu: RTL and testbench

Parametrised byte-addressable data memory with an integrated load/store path for the single-cycle/pipelined core's MEM stage. Supports byte/half/word/double accesses with sign or zero extension. Splits misaligned accesses that cross a word boundary into two internal cycles, and answers every request through a valid/ready handshake. Optionally maps a small LED/switch I/O window into the top of the address space.

---
 rtl/dmem_lsu.sv | 222 ++++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable data memory with load/store path for the MEM stage.
// Byte/half/word/double accesses with sign/zero extension. Accesses that cross
// a word boundary are split over two cycles. Every request gets exactly one
// response pulse, in request order.
// Optional feature macro: DMEM_LSU_IO_EN maps LEDR/LEDG/switch registers into
// the top four words of the address space.
module dmem_lsu #(
    parameter int DW = 32,
    parameter int AW = 11
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o
`ifdef DMEM_LSU_IO_EN
    ,
    input  logic [DW-1:0] io_sw_i,
    output logic [DW-1:0] io_ledr_o,
    output logic [DW-1:0] io_ledg_o
`endif
);

    localparam int NB    = DW / 8;
    localparam int OW    = $clog2(NB);
    localparam int WI    = AW - OW;
    localparam int WORDS = 1 << WI;

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t state_q;

    logic [DW-1:0] mem [WORDS];

    // Second-half context captured on the accept edge of a split access
    logic [WI-1:0] idx_q;
    logic [OW-1:0] off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          we_q;
    logic [DW-1:0] lo_q;
    logic [DW-1:0] wd_hi_q;
    logic [NB-1:0] be_hi_q;

    // Request decode
    logic [3:0]      nbytes;
    logic [OW-1:0]   off;
    logic [WI-1:0]   idx;
    logic [AW+3:0]   end_addr;
    logic            legal;
    logic            range_err;
    logic            split;
    logic            io_err;
    logic            err;
    logic            go_split;
    logic            accept;
    logic            ram_we_lo;
    logic [2*NB-1:0] be_base;
    logic [2*NB-1:0] wide_be;
    logic [2*DW-1:0] wide_wd;
    logic [DW-1:0]   rd_word;
    logic [DW-1:0]   aligned_rdata;
    logic [DW-1:0]   split_rdata;
    logic [DW-1:0]   hi_word;
`ifdef DMEM_LSU_IO_EN
    logic            is_io_lo;
    logic            is_io_hi;
    logic [WI-1:0]   idx_nx;
    logic [DW-1:0]   io_rd;
`endif

    // Keep the low 8*B bits of raw and extend to DW by sign or zero
    function automatic logic [DW-1:0] extend(input logic [DW-1:0] raw,
                                             input logic [1:0]    size,
                                             input logic          uns);
        int unsigned nbits;
        logic        sign;
        logic [DW-1:0] res;
        nbits = 32'd8 << size;
        sign  = 1'b0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (i + 1 == nbits) sign = raw[i];
        end
        for (int unsigned i = 0; i < DW; i++) begin
            res[i] = (i < nbits) ? raw[i] : (!uns && sign);
        end
        return res;
    endfunction

    assign req_ready_o = (state_q == IDLE);

    // Decode the request, build lane masks and the read word for the accept edge
    always_comb begin
        nbytes    = 4'd1 << req_size_i;
        off       = req_addr_i[OW-1:0];
        idx       = req_addr_i[AW-1:OW];
        end_addr  = (AW+4)'(req_addr_i) + (AW+4)'(nbytes);
        legal     = (32'(nbytes) * 32'd8) <= 32'(DW);
        range_err = end_addr > ((AW+4)'(1) << AW);
        split     = (32'(off) + 32'(nbytes)) > 32'(NB);
        io_err    = 1'b0;
        rd_word   = mem[idx];
`ifdef DMEM_LSU_IO_EN
        idx_nx   = idx + WI'(1);
        is_io_lo = &idx[WI-1:2];
        is_io_hi = &idx_nx[WI-1:2];
        io_err   = split && (is_io_lo || is_io_hi);
        case (idx[1:0])
            2'd0:    io_rd = io_ledr_o;
            2'd1:    io_rd = io_ledg_o;
            2'd2:    io_rd = io_sw_i;
            default: io_rd = '0;
        endcase
        if (is_io_lo) rd_word = io_rd;
`endif
        err       = !legal || range_err || io_err;
        go_split  = !err && split;
        accept    = req_valid_i && req_ready_o && rst_ni;
        ram_we_lo = accept && req_we_i && !err;
`ifdef DMEM_LSU_IO_EN
        ram_we_lo = ram_we_lo && !is_io_lo;
`endif
        // Byte lanes over two adjacent words: lower NB lanes hit idx, upper NB hit idx+1
        be_base = (2*NB)'((16'd1 << nbytes) - 16'd1);
        wide_be = be_base << off;
        wide_wd = {{DW{1'b0}}, req_wdata_i} << {off, 3'b000};

        aligned_rdata = extend(DW'(rd_word >> {off, 3'b000}), req_size_i, req_unsigned_i);
        hi_word       = mem[idx_q + WI'(1)];
        split_rdata   = extend(DW'({hi_word, lo_q} >> {off_q, 3'b000}), size_q, uns_q);
    end

    // RAM writes: lower lanes on the accept edge, upper lanes on the SPLIT edge
    always_ff @(posedge clk_i) begin
        if (ram_we_lo) begin
            for (int unsigned j = 0; j < NB; j++) begin
                if (wide_be[j]) mem[idx][8*j +: 8] <= wide_wd[8*j +: 8];
            end
        end
        if (state_q == SPLIT && we_q) begin
            for (int unsigned j = 0; j < NB; j++) begin
                if (be_hi_q[j]) mem[idx_q + WI'(1)][8*j +: 8] <= wd_hi_q[8*j +: 8];
            end
        end
    end

`ifdef DMEM_LSU_IO_EN
    // LED registers: byte-lane writes from aligned accesses into I/O words 0 and 1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            io_ledr_o <= '0;
            io_ledg_o <= '0;
        end else if (accept && req_we_i && !err && is_io_lo) begin
            for (int unsigned j = 0; j < NB; j++) begin
                if (wide_be[j]) begin
                    if (idx[1:0] == 2'd0) io_ledr_o[8*j +: 8] <= wide_wd[8*j +: 8];
                    if (idx[1:0] == 2'd1) io_ledg_o[8*j +: 8] <= wide_wd[8*j +: 8];
                end
            end
        end
    end
`endif

    // Control FSM with registered response outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            idx_q       <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            lo_q        <= '0;
            wd_hi_q     <= '0;
            be_hi_q     <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (go_split) begin
                            state_q <= SPLIT;
                            idx_q   <= idx;
                            off_q   <= off;
                            size_q  <= req_size_i;
                            uns_q   <= req_unsigned_i;
                            we_q    <= req_we_i;
                            lo_q    <= rd_word;
                            wd_hi_q <= wide_wd[2*DW-1:DW];
                            be_hi_q <= wide_be[2*NB-1:NB];
                        end else begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= err;
                            rsp_rdata_o <= (err || req_we_i) ? '0 : aligned_rdata;
                        end
                    end
                end
                SPLIT: begin
                    state_q     <= IDLE;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= we_q ? '0 : split_rdata;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu (DW=32, AW=11): directed vector table plus
// hand-written sequences for back-to-back traffic and reset during a split.
// I/O window checks are included when DMEM_LSU_IO_EN is defined.
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_LSU_IO_EN
    logic [31:0] io_sw;
    logic [31:0] io_ledr;
    logic [31:0] io_ledg;
`endif

    int tests = 0;
    int fails = 0;

    dmem_lsu #(.DW(32), .AW(11)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err)
`ifdef DMEM_LSU_IO_EN
        ,
        .io_sw_i        (io_sw),
        .io_ledr_o      (io_ledr),
        .io_ledg_o      (io_ledg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [1:0] size, input logic uns,
                       input logic [10:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err, input int lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One request: drive on negedge, accept on posedge, wait up to 5 cycles for the response
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [10:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic rdy_after);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rd = '0; er = 1'b0; rdy_after = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) rdy_after = req_ready;
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        rdy;
        do_req(v.we, v.size, v.uns, v.addr, v.wdata, rd, er, lat, rdy);
        check({tag, "_rdata"}, rd, v.rdata);
        check({tag, "_err"}, {31'd0, er}, {31'd0, v.err});
        check({tag, "_lat"}, lat, v.lat);
        check({tag, "_ready_after"}, {31'd0, rdy}, (v.lat == 2) ? 32'd0 : 32'd1);
    endtask

    logic [31:0] bb_exp [8];
    logic        any_valid;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_uns = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef DMEM_LSU_IO_EN
        io_sw = 32'h0000_003C;
`endif

        // Vector table: {we, size, uns, addr, wdata, exp rdata, exp err, exp latency}
        add(1, 2, 0, 11'h010, 32'hDEADBEEF, 32'h00000000, 0, 1);
        add(0, 2, 0, 11'h010, 32'h0,        32'hDEADBEEF, 0, 1);
        add(0, 0, 0, 11'h013, 32'h0,        32'hFFFFFFDE, 0, 1);
        add(0, 0, 1, 11'h013, 32'h0,        32'h000000DE, 0, 1);
        add(0, 1, 0, 11'h012, 32'h0,        32'hFFFFDEAD, 0, 1);
        add(0, 1, 1, 11'h010, 32'h0,        32'h0000BEEF, 0, 1);
        add(1, 2, 0, 11'h020, 32'hAABBCCDD, 32'h00000000, 0, 1);
        add(1, 2, 0, 11'h024, 32'h55667788, 32'h00000000, 0, 1);
        add(1, 2, 0, 11'h022, 32'h11223344, 32'h00000000, 0, 2);
        add(0, 2, 0, 11'h022, 32'h0,        32'h11223344, 0, 2);
        add(0, 2, 0, 11'h020, 32'h0,        32'h3344CCDD, 0, 1);
        add(0, 2, 0, 11'h024, 32'h0,        32'h55661122, 0, 1);
        add(1, 2, 0, 11'h030, 32'hCAFEF00D, 32'h00000000, 0, 1);
        add(1, 3, 0, 11'h030, 32'hFFFFFFFF, 32'h00000000, 1, 1);
        add(0, 3, 0, 11'h030, 32'h0,        32'h00000000, 1, 1);
        add(0, 2, 0, 11'h030, 32'h0,        32'hCAFEF00D, 0, 1);
        add(1, 2, 0, 11'h040, 32'h00000000, 32'h00000000, 0, 1);
        add(1, 2, 0, 11'h044, 32'h00000000, 32'h00000000, 0, 1);
        add(1, 1, 0, 11'h043, 32'hFFFF8081, 32'h00000000, 0, 2);
        add(0, 1, 0, 11'h043, 32'h0,        32'hFFFF8081, 0, 2);
        add(0, 2, 0, 11'h040, 32'h0,        32'h81000000, 0, 1);
        add(0, 2, 0, 11'h044, 32'h0,        32'h00000080, 0, 1);
        add(0, 0, 1, 11'h043, 32'h0,        32'h00000081, 0, 1);
        add(0, 2, 0, 11'h7FE, 32'h0,        32'h00000000, 1, 1);
        add(0, 2, 0, 11'h7FD, 32'h0,        32'h00000000, 1, 1);
`ifndef DMEM_LSU_IO_EN
        add(1, 2, 0, 11'h7FC, 32'h01234567, 32'h00000000, 0, 1);
        add(1, 2, 0, 11'h7FE, 32'hFFFFFFFF, 32'h00000000, 1, 1);
        add(0, 2, 0, 11'h7FC, 32'h0,        32'h01234567, 0, 1);
        add(0, 1, 1, 11'h7FE, 32'h0,        32'h00000123, 0, 1);
        add(0, 0, 0, 11'h7FF, 32'h0,        32'h00000001, 0, 1);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", {31'd0, rsp_err}, 32'd0);
`ifdef DMEM_LSU_IO_EN
        check("reset_ledr", io_ledr, 32'd0);
        check("reset_ledg", io_ledg, 32'd0);
`endif
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back aligned traffic: one request per cycle, responses one cycle later
        begin
            logic        bw [8];
            logic [1:0]  bs [8];
            logic        bu [8];
            logic [10:0] ba [8];
            logic [31:0] bd [8];
            bw = '{1, 0, 1, 0, 1, 0, 0, 0};
            bs = '{2, 2, 0, 2, 1, 2, 0, 1};
            bu = '{0, 0, 0, 0, 0, 0, 0, 1};
            ba = '{11'h050, 11'h050, 11'h051, 11'h050, 11'h052, 11'h050, 11'h053, 11'h050};
            bd = '{32'h12345678, 0, 32'h000000AB, 0, 32'h0000CDEF, 0, 0, 0};
            bb_exp = '{32'h0, 32'h12345678, 32'h0, 32'h1234AB78, 32'h0,
                       32'hCDEFAB78, 32'hFFFFFFCD, 32'h0000AB78};
            for (int i = 0; i <= 8; i++) begin
                @(negedge clk);
                if (i > 0) begin
                    check($sformatf("b2b%0d_valid", i - 1), {31'd0, rsp_valid}, 32'd1);
                    check($sformatf("b2b%0d_rdata", i - 1), rsp_rdata, bb_exp[i-1]);
                end
                if (i < 8) begin
                    check($sformatf("b2b%0d_ready", i), {31'd0, req_ready}, 32'd1);
                    req_valid = 1'b1; req_we = bw[i]; req_size = bs[i]; req_uns = bu[i];
                    req_addr = ba[i]; req_wdata = bd[i];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
            check("b2b_quiet", {31'd0, rsp_valid}, 32'd0);
        end

        // Reset asserted while a split store is in SPLIT
        begin
            logic [31:0] rd;
            logic        er;
            int          lat;
            logic        rdy;
            do_req(1, 2, 0, 11'h060, 32'h0, rd, er, lat, rdy);
            do_req(1, 2, 0, 11'h064, 32'h0, rd, er, lat, rdy);
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0;
            req_addr = 11'h062; req_wdata = 32'hA1B2C3D4;
            @(posedge clk);
            #1 req_valid = 1'b0;
            check("split_rst_ready_before", {31'd0, req_ready}, 32'd0);
            #2 rst_n = 1'b0;
            #1;
            check("split_rst_ready", {31'd0, req_ready}, 32'd1);
            check("split_rst_valid", {31'd0, rsp_valid}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            any_valid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (rsp_valid) any_valid = 1'b1;
            end
            check("split_rst_no_rsp", {31'd0, any_valid}, 32'd0);
            do_req(0, 2, 0, 11'h060, 32'h0, rd, er, lat, rdy);
            check("split_rst_lo_word", rd, 32'hC3D40000);
            do_req(0, 2, 0, 11'h064, 32'h0, rd, er, lat, rdy);
            check("split_rst_hi_word", rd, 32'h00000000);
        end

`ifdef DMEM_LSU_IO_EN
        // I/O window at byte base 0x7F0
        begin
            logic [31:0] rd;
            logic        er;
            int          lat;
            logic        rdy;
            do_req(1, 2, 0, 11'h7F0, 32'h000000A5, rd, er, lat, rdy);
            check("io_ledr_out", io_ledr, 32'h000000A5);
            do_req(0, 2, 0, 11'h7F0, 32'h0, rd, er, lat, rdy);
            check("io_ledr_read", rd, 32'h000000A5);
            do_req(1, 0, 0, 11'h7F4, 32'h0000005A, rd, er, lat, rdy);
            check("io_ledg_out", io_ledg, 32'h0000005A);
            do_req(0, 2, 0, 11'h7F8, 32'h0, rd, er, lat, rdy);
            check("io_sw_read", rd, 32'h0000003C);
            do_req(1, 2, 0, 11'h7F8, 32'hFFFFFFFF, rd, er, lat, rdy);
            check("io_sw_write_err", {31'd0, er}, 32'd0);
            do_req(0, 2, 0, 11'h7F8, 32'h0, rd, er, lat, rdy);
            check("io_sw_unchanged", rd, 32'h0000003C);
            do_req(0, 2, 0, 11'h7FC, 32'h0, rd, er, lat, rdy);
            check("io_word3_zero", rd, 32'h00000000);
            do_req(0, 2, 0, 11'h7EE, 32'h0, rd, er, lat, rdy);
            check("io_split_err", {31'd0, er}, 32'd1);
            check("io_split_err_lat", lat, 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
